// File: rtl/hd_program_loader.sv
// Copies one HD program block into instruction memory, or scans all HD block
// headers for the lowest free block (header word == 0).
module hd_program_loader #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned BLOCK_SIZE = 200,
   parameter int unsigned NUM_BLOCKS = 8
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [1:0]        cmd_i,
   input  logic [7:0]        block_idx_i,
   output logic              hd_rd_en_o,
   output logic [ADDR_W-1:0] hd_addr_o,
   input  logic [DATA_W-1:0] hd_rdata_i,
   output logic              im_we_o,
   output logic [ADDR_W-1:0] im_addr_o,
   output logic [DATA_W-1:0] im_wdata_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o,
   output logic [ADDR_W-1:0] words_loaded_o,
   output logic              free_found_o,
   output logic [7:0]        free_block_o,
   output logic [7:0]        used_count_o
);

   localparam int unsigned MAX_LEN  = BLOCK_SIZE - 1;
   localparam logic [1:0]  CMD_LOAD = 2'b01;
   localparam logic [1:0]  CMD_SCAN = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR,
      S_HDR_WAIT,
      S_COPY,
      S_FLUSH,
      S_SCAN,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic                hd_rd_en_q, hd_rd_en_d;
   logic [ADDR_W-1:0]   hd_addr_q, hd_addr_d;
   logic                im_we_q, im_we_d;
   logic [ADDR_W-1:0]   im_addr_q, im_addr_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [ADDR_W-1:0]   words_q, words_d;
   logic                free_found_q, free_found_d;
   logic [7:0]          free_block_q, free_block_d;
   logic [7:0]          used_count_q, used_count_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]   idx_q, idx_d;

   logic                blk_ok;
   logic [ADDR_W-1:0]   base;

   assign blk_ok = 32'(block_idx_i) < NUM_BLOCKS;
   assign base   = ADDR_W'(block_idx_i) * ADDR_W'(BLOCK_SIZE);

   // Registered outputs are computed one cycle ahead so they line up with the state they belong to
   always_comb begin
      state_d      = state_q;
      hd_rd_en_d   = 1'b0;
      hd_addr_d    = hd_addr_q;
      im_we_d      = 1'b0;
      im_addr_d    = im_addr_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      err_d        = err_q;
      words_d      = words_q;
      free_found_d = free_found_q;
      free_block_d = free_block_q;
      used_count_d = used_count_q;
      len_d        = len_q;
      idx_d        = idx_q;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               err_d        = 1'b0;
               words_d      = '0;
               free_found_d = 1'b0;
               free_block_d = '0;
               used_count_d = '0;
               idx_d        = '0;
               if (cmd_i == CMD_LOAD && blk_ok) begin
                  state_d    = S_HDR;
                  hd_rd_en_d = 1'b1;
                  hd_addr_d  = base;
                  busy_d     = 1'b1;
               end else if (cmd_i == CMD_SCAN) begin
                  state_d    = S_SCAN;
                  hd_rd_en_d = 1'b1;
                  hd_addr_d  = '0;
                  busy_d     = 1'b1;
               end else begin
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end

         S_HDR: state_d = S_HDR_WAIT;

         S_HDR_WAIT: begin
            if (hd_rdata_i == '0) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               if (hd_rdata_i > DATA_W'(MAX_LEN)) begin
                  len_d = ADDR_W'(MAX_LEN);
                  err_d = 1'b1;
               end else begin
                  len_d = ADDR_W'(hd_rdata_i);
               end
               state_d    = S_COPY;
               hd_rd_en_d = 1'b1;
               hd_addr_d  = hd_addr_q + ADDR_W'(1);
               idx_d      = '0;
            end
         end

         // idx_q is the body word being read; it is written to IM on the next cycle
         S_COPY: begin
            im_we_d   = 1'b1;
            im_addr_d = idx_q;
            idx_d     = idx_q + ADDR_W'(1);
            if (idx_q + ADDR_W'(1) < len_q) begin
               hd_rd_en_d = 1'b1;
               hd_addr_d  = hd_addr_q + ADDR_W'(1);
            end else begin
               state_d = S_FLUSH;
            end
         end

         S_FLUSH: begin
            state_d = S_DONE;
            words_d = len_q;
            done_d  = 1'b1;
            busy_d  = 1'b0;
         end

         // idx_q counts issued header reads; header idx_q-1 arrives this cycle
         S_SCAN: begin
            idx_d = idx_q + ADDR_W'(1);
            if (idx_q != '0) begin
               if (hd_rdata_i != '0) begin
                  used_count_d = used_count_q + 8'd1;
               end else if (!free_found_q) begin
                  free_found_d = 1'b1;
                  free_block_d = 8'(idx_q - ADDR_W'(1));
               end
            end
            if (idx_q + ADDR_W'(1) < ADDR_W'(NUM_BLOCKS)) begin
               hd_rd_en_d = 1'b1;
               hd_addr_d  = hd_addr_q + ADDR_W'(BLOCK_SIZE);
            end
            if (idx_q == ADDR_W'(NUM_BLOCKS)) begin
               state_d = S_DONE;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end
         end

         S_DONE: state_d = S_IDLE;

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_IDLE;
         hd_rd_en_q   <= 1'b0;
         hd_addr_q    <= '0;
         im_we_q      <= 1'b0;
         im_addr_q    <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         words_q      <= '0;
         free_found_q <= 1'b0;
         free_block_q <= '0;
         used_count_q <= '0;
         len_q        <= '0;
         idx_q        <= '0;
      end else begin
         state_q      <= state_d;
         hd_rd_en_q   <= hd_rd_en_d;
         hd_addr_q    <= hd_addr_d;
         im_we_q      <= im_we_d;
         im_addr_q    <= im_addr_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
         words_q      <= words_d;
         free_found_q <= free_found_d;
         free_block_q <= free_block_d;
         used_count_q <= used_count_d;
         len_q        <= len_d;
         idx_q        <= idx_d;
      end
   end

   // HD data is only valid in the write cycle itself, so write data bypasses the register stage
   assign im_wdata_o     = im_we_q ? hd_rdata_i : '0;
   assign hd_rd_en_o     = hd_rd_en_q;
   assign hd_addr_o      = hd_addr_q;
   assign im_we_o        = im_we_q;
   assign im_addr_o      = im_addr_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign err_o          = err_q;
   assign words_loaded_o = words_q;
   assign free_found_o   = free_found_q;
   assign free_block_o   = free_block_q;
   assign used_count_o   = used_count_q;

endmodule

// File: tb/tb_hd_program_loader.sv
// Bench for hd_program_loader: directed cases plus random commands checked
// against a queue-based reference model of the HD/IM transfer.
module tb_hd_program_loader;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned BS = 200;
   localparam int unsigned NB = 8;
   localparam int unsigned HD_WORDS = BS * NB;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [1:0]    cmd;
   logic [7:0]    bidx;
   logic          hd_rd_en;
   logic [AW-1:0] hd_addr;
   logic [DW-1:0] hd_rdata;
   logic          im_we;
   logic [AW-1:0] im_addr;
   logic [DW-1:0] im_wdata;
   logic          busy, done, err;
   logic [AW-1:0] words_loaded;
   logic          free_found;
   logic [7:0]    free_block, used_count;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] hd_mem [HD_WORDS];

   logic [31:0] cap_wa[$], cap_wd[$], cap_ra[$];
   int          cap_lat;
   bit          cap_busy_ok;
   logic        cap_done2, cap_err, cap_ff;
   logic [31:0] cap_wl;
   logic [7:0]  cap_fb, cap_uc;
   bit          spam_start = 1'b0;

   logic [31:0] exp_wa[$], exp_wd[$], exp_ra[$];
   int          exp_lat;
   logic        exp_err, exp_ff;
   logic [31:0] exp_wl;
   logic [7:0]  exp_fb, exp_uc;

   hd_program_loader #(.DATA_W(DW), .ADDR_W(AW), .BLOCK_SIZE(BS), .NUM_BLOCKS(NB)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .cmd_i(cmd), .block_idx_i(bidx),
      .hd_rd_en_o(hd_rd_en), .hd_addr_o(hd_addr), .hd_rdata_i(hd_rdata),
      .im_we_o(im_we), .im_addr_o(im_addr), .im_wdata_o(im_wdata),
      .busy_o(busy), .done_o(done), .err_o(err), .words_loaded_o(words_loaded),
      .free_found_o(free_found), .free_block_o(free_block), .used_count_o(used_count)
   );

   always #5 clk = ~clk;

   // HD read port: data appears the cycle after the request
   always @(posedge clk) begin
      if (hd_rd_en) hd_rdata <= (hd_addr < HD_WORDS) ? hd_mem[hd_addr] : 32'hDEAD_BEEF;
   end

   function automatic bit q_eq(input logic [31:0] a[$], input logic [31:0] b[$]);
      if (a.size() != b.size()) return 1'b0;
      foreach (a[k]) if (a[k] !== b[k]) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit seq_ok(input logic [31:0] q[$], input logic [31:0] first,
                                 input logic [31:0] step, input int cnt);
      if (q.size() != cnt) return 1'b0;
      foreach (q[k]) if (q[k] !== first + step * 32'(k)) return 1'b0;
      return 1'b1;
   endfunction

   task automatic fill_random();
      for (int a = 0; a < int'(HD_WORDS); a++) hd_mem[a] = $urandom;
   endtask

   // Issue one command and record every HD read and IM write until done
   task automatic run_cmd(input logic [1:0] c, input logic [7:0] b);
      int n;
      cap_wa.delete(); cap_wd.delete(); cap_ra.delete();
      cap_lat = -1; cap_busy_ok = 1'b1;
      @(posedge clk); #1;
      start = 1'b1; cmd = c; bidx = b;
      @(posedge clk); #1;
      start = 1'b0; cmd = 2'($urandom); bidx = 8'($urandom);
      if (spam_start) begin start = 1'b1; cmd = 2'b10; end
      @(negedge clk);
      n = 1;
      while (n < 2000) begin
         if (hd_rd_en) cap_ra.push_back(hd_addr);
         if (im_we) begin cap_wa.push_back(im_addr); cap_wd.push_back(im_wdata); end
         if (done) begin
            cap_lat = n; cap_err = err; cap_wl = words_loaded;
            cap_ff = free_found; cap_fb = free_block; cap_uc = used_count;
            if (busy) cap_busy_ok = 1'b0;
            start = 1'b0;
            break;
         end
         if (!busy) cap_busy_ok = 1'b0;
         @(negedge clk);
         n++;
      end
      start = 1'b0;
      @(negedge clk);
      cap_done2 = done;
   endtask

   // Reference model: expected transfer derived from the HD image and the command rules
   task automatic model_cmd(input logic [1:0] c, input logic [7:0] b);
      logic [31:0] h, len, base;
      exp_wa.delete(); exp_wd.delete(); exp_ra.delete();
      exp_err = 1'b0; exp_wl = '0; exp_ff = 1'b0; exp_fb = '0; exp_uc = '0;
      if (c == 2'b01 && int'(b) < int'(NB)) begin
         base = 32'(b) * BS;
         h    = hd_mem[base];
         len  = (h > BS - 1) ? BS - 1 : h;
         exp_err = (h > BS - 1);
         exp_ra.push_back(base);
         for (int i = 0; i < int'(len); i++) begin
            exp_ra.push_back(base + 1 + 32'(i));
            exp_wa.push_back(32'(i));
            exp_wd.push_back(hd_mem[base + 1 + 32'(i)]);
         end
         exp_wl  = len;
         exp_lat = (len == 0) ? 3 : int'(len) + 4;
      end else if (c == 2'b10) begin
         for (int k = 0; k < int'(NB); k++) begin
            exp_ra.push_back(32'(k) * BS);
            if (hd_mem[k * BS] != 0) exp_uc = exp_uc + 8'd1;
            else if (!exp_ff) begin exp_ff = 1'b1; exp_fb = 8'(k); end
         end
         exp_lat = NB + 2;
      end else begin
         exp_err = 1'b1;
         exp_lat = 1;
      end
   endtask

   task automatic test_reset();
      logic [149:0] all_out;
      rst_n = 1'b0; start = 1'b0; cmd = '0; bidx = '0;
      repeat (3) @(posedge clk);
      #1;
      all_out = {hd_rd_en, hd_addr, im_we, im_addr, im_wdata, busy, done, err,
                 words_loaded, free_found, free_block, used_count};
      n_checks++;
      if (all_out !== '0) begin
         n_fail++; $display("FAIL reset_outputs: got %h want 0", all_out);
      end
      @(negedge clk); rst_n = 1'b1;
   endtask

   task automatic test_load_basic();
      fill_random();
      hd_mem[400] = 32'd5;
      for (int i = 0; i < 5; i++) hd_mem[401 + i] = 32'hA0 + 32'(i);
      run_cmd(2'b01, 8'd2);
      n_checks++; if (cap_lat !== 9) begin n_fail++; $display("FAIL load_basic.lat: got %0d want 9", cap_lat); end
      n_checks++; if (cap_err !== 1'b0) begin n_fail++; $display("FAIL load_basic.err: got %b want 0", cap_err); end
      n_checks++; if (cap_wl !== 32'd5) begin n_fail++; $display("FAIL load_basic.words: got %0d want 5", cap_wl); end
      n_checks++;
      if (!seq_ok(cap_wa, 0, 1, 5) || !seq_ok(cap_wd, 32'hA0, 1, 5)) begin
         n_fail++; $display("FAIL load_basic.writes: got %0d writes, want IM[0..4]=A0..A4", cap_wa.size());
      end
      n_checks++;
      if (!seq_ok(cap_ra, 400, 1, 6)) begin
         n_fail++; $display("FAIL load_basic.hd_addr: got %0d reads, want 400..405", cap_ra.size());
      end
      n_checks++; if (!cap_busy_ok) begin n_fail++; $display("FAIL load_basic.busy: got bad busy, want 1 until done"); end
      n_checks++; if (cap_done2 !== 1'b0) begin n_fail++; $display("FAIL load_basic.done_pulse: got %b want 0", cap_done2); end
   endtask

   task automatic test_load_empty();
      fill_random();
      hd_mem[200] = 32'd0;
      run_cmd(2'b01, 8'd1);
      n_checks++; if (cap_lat !== 3) begin n_fail++; $display("FAIL load_empty.lat: got %0d want 3", cap_lat); end
      n_checks++;
      if (cap_wa.size() != 0 || cap_wl !== 32'd0 || cap_err !== 1'b0) begin
         n_fail++; $display("FAIL load_empty.result: got writes=%0d words=%0d err=%b want 0/0/0",
                            cap_wa.size(), cap_wl, cap_err);
      end
      n_checks++; if (!seq_ok(cap_ra, 200, 1, 1)) begin n_fail++; $display("FAIL load_empty.reads: got %0d want 1 read at 200", cap_ra.size()); end
   endtask

   task automatic test_load_clamp();
      fill_random();
      hd_mem[0] = 32'd500;
      for (int i = 1; i < int'(BS); i++) hd_mem[i] = 32'd1000 + 32'(i - 1);
      run_cmd(2'b01, 8'd0);
      n_checks++; if (cap_lat !== 203) begin n_fail++; $display("FAIL load_clamp.lat: got %0d want 203", cap_lat); end
      n_checks++; if (cap_wl !== 32'd199) begin n_fail++; $display("FAIL load_clamp.words: got %0d want 199", cap_wl); end
      n_checks++; if (cap_err !== 1'b1) begin n_fail++; $display("FAIL load_clamp.err: got %b want 1", cap_err); end
      n_checks++;
      if (!seq_ok(cap_wa, 0, 1, 199) || !seq_ok(cap_wd, 1000, 1, 199)) begin
         n_fail++; $display("FAIL load_clamp.writes: got %0d writes want 199", cap_wa.size());
      end
   endtask

   task automatic test_illegal();
      logic [1:0] cs [3];
      logic [7:0] bs [3];
      cs[0] = 2'b01; bs[0] = 8'd8;
      cs[1] = 2'b11; bs[1] = 8'd3;
      cs[2] = 2'b00; bs[2] = 8'd0;
      for (int t = 0; t < 3; t++) begin
         run_cmd(cs[t], bs[t]);
         n_checks++;
         if (cap_lat !== 1 || cap_err !== 1'b1 || cap_ra.size() != 0 || cap_wa.size() != 0) begin
            n_fail++; $display("FAIL illegal[%0d]: got lat=%0d err=%b reads=%0d writes=%0d want 1/1/0/0",
                               t, cap_lat, cap_err, cap_ra.size(), cap_wa.size());
         end
      end
   endtask

   task automatic test_scan();
      logic [31:0] hdr [8];
      hdr = '{32'd3, 32'd7, 32'd0, 32'd4, 32'd0, 32'd1, 32'd2, 32'd9};
      fill_random();
      for (int k = 0; k < 8; k++) hd_mem[k * BS] = hdr[k];
      run_cmd(2'b10, 8'd0);
      n_checks++; if (cap_lat !== 10) begin n_fail++; $display("FAIL scan.lat: got %0d want 10", cap_lat); end
      n_checks++;
      if (cap_ff !== 1'b1 || cap_fb !== 8'd2 || cap_uc !== 8'd6) begin
         n_fail++; $display("FAIL scan.result: got ff=%b fb=%0d uc=%0d want 1/2/6", cap_ff, cap_fb, cap_uc);
      end
      n_checks++; if (!seq_ok(cap_ra, 0, BS, 8)) begin n_fail++; $display("FAIL scan.reads: got %0d want 8 headers", cap_ra.size()); end
      n_checks++; if (cap_wa.size() != 0) begin n_fail++; $display("FAIL scan.no_write: got %0d want 0", cap_wa.size()); end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if (free_found !== 1'b1 || free_block !== 8'd2 || used_count !== 8'd6) begin
         n_fail++; $display("FAIL scan.hold: got ff=%b fb=%0d uc=%0d want 1/2/6", free_found, free_block, used_count);
      end
      for (int k = 0; k < 8; k++) hd_mem[k * BS] = 32'd1 + 32'(k);
      run_cmd(2'b10, 8'd5);
      n_checks++;
      if (cap_ff !== 1'b0 || cap_fb !== 8'd0 || cap_uc !== 8'd8) begin
         n_fail++; $display("FAIL scan_full: got ff=%b fb=%0d uc=%0d want 0/0/8", cap_ff, cap_fb, cap_uc);
      end
   endtask

   task automatic test_start_while_busy();
      fill_random();
      hd_mem[3 * BS] = 32'd4;
      model_cmd(2'b01, 8'd3);
      spam_start = 1'b1;
      run_cmd(2'b01, 8'd3);
      spam_start = 1'b0;
      n_checks++;
      if (cap_lat !== exp_lat || !q_eq(cap_ra, exp_ra) || !q_eq(cap_wd, exp_wd) || cap_uc !== 8'd0) begin
         n_fail++; $display("FAIL start_while_busy: got lat=%0d reads=%0d uc=%0d want %0d/%0d/0",
                            cap_lat, cap_ra.size(), cap_uc, exp_lat, exp_ra.size());
      end
   endtask

   task automatic test_reset_mid_load();
      int nw;
      logic [149:0] all_out;
      fill_random();
      hd_mem[400] = 32'd5;
      for (int i = 0; i < 5; i++) hd_mem[401 + i] = 32'hA0 + 32'(i);
      @(posedge clk); #1;
      start = 1'b1; cmd = 2'b01; bidx = 8'd2;
      @(posedge clk); #1;
      start = 1'b0;
      nw = 0;
      for (int c = 0; c < 50 && nw < 3; c++) begin
         @(negedge clk);
         if (im_we) nw++;
      end
      n_checks++; if (nw != 3) begin n_fail++; $display("FAIL reset_mid.reach: got %0d writes want 3", nw); end
      #1 rst_n = 1'b0;
      #1;
      all_out = {hd_rd_en, hd_addr, im_we, im_addr, im_wdata, busy, done, err,
                 words_loaded, free_found, free_block, used_count};
      n_checks++;
      if (all_out !== '0) begin n_fail++; $display("FAIL reset_mid.async: got %h want 0", all_out); end
      @(negedge clk); rst_n = 1'b1;
      run_cmd(2'b01, 8'd2);
      n_checks++;
      if (cap_lat !== 9 || !seq_ok(cap_wd, 32'hA0, 1, 5) || cap_wl !== 32'd5) begin
         n_fail++; $display("FAIL reset_mid.reload: got lat=%0d writes=%0d words=%0d want 9/5/5",
                            cap_lat, cap_wd.size(), cap_wl);
      end
   endtask

   task automatic test_random();
      int r;
      logic [1:0] c;
      logic [7:0] b;
      for (int it = 0; it < 40; it++) begin
         fill_random();
         for (int k = 0; k < int'(NB); k++) begin
            r = $urandom_range(0, 3);
            case (r)
               0:       hd_mem[k * BS] = 32'd0;
               1:       hd_mem[k * BS] = 32'($urandom_range(1, 20));
               2:       hd_mem[k * BS] = 32'($urandom_range(BS - 2, BS + 2));
               default: hd_mem[k * BS] = hd_mem[k * BS];
            endcase
         end
         r = $urandom_range(0, 9);
         c = (r < 5) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b00 : 2'b11;
         b = 8'($urandom_range(0, 9));
         model_cmd(c, b);
         run_cmd(c, b);
         n_checks++;
         if (cap_lat !== exp_lat) begin
            n_fail++; $display("FAIL rand[%0d].lat: got %0d want %0d", it, cap_lat, exp_lat);
         end
         n_checks++;
         if (cap_err !== exp_err || cap_wl !== exp_wl) begin
            n_fail++; $display("FAIL rand[%0d].load: got err=%b words=%0d want %b/%0d", it, cap_err, cap_wl, exp_err, exp_wl);
         end
         n_checks++;
         if (cap_ff !== exp_ff || cap_fb !== exp_fb || cap_uc !== exp_uc) begin
            n_fail++; $display("FAIL rand[%0d].scan: got %b/%0d/%0d want %b/%0d/%0d",
                               it, cap_ff, cap_fb, cap_uc, exp_ff, exp_fb, exp_uc);
         end
         n_checks++;
         if (!q_eq(cap_wa, exp_wa) || !q_eq(cap_wd, exp_wd) || !q_eq(cap_ra, exp_ra)) begin
            n_fail++; $display("FAIL rand[%0d].traffic: got reads=%0d writes=%0d want %0d/%0d",
                               it, cap_ra.size(), cap_wa.size(), exp_ra.size(), exp_wa.size());
         end
         n_checks++;
         if (!cap_busy_ok || cap_done2 !== 1'b0) begin
            n_fail++; $display("FAIL rand[%0d].handshake: got busy_ok=%b done_next=%b want 1/0", it, cap_busy_ok, cap_done2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_load_basic();
      test_load_empty();
      test_load_clamp();
      test_illegal();
      test_scan();
      test_start_while_busy();
      test_reset_mid_load();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
